// File: rtl/mem_request_queue.sv
// Bounded in-order request queue between the trace parser and the DRAM command
// controller. NOPs are dropped and counted; each entry's life ages every cycle.
package global_defs;
  typedef enum logic [1:0] {
    DATA_READ    = 2'd0,
    DATA_WRITE   = 2'd1,
    OPCODE_FETCH = 2'd2,
    NOP          = 2'd3
  } op_t;

  typedef struct packed {
    logic [31:0] CPU_clock_count;
    op_t         opcode;
    logic [31:0] address;
    logic [6:0]  life;
    logic        op_ready_s;
  } parser_out_struct;
endpackage

module mem_request_queue
  import global_defs::*;
#(
  parameter int QUEUE_DEPTH = 16,
  parameter int AGE_LIMIT   = 100
) (
  input  logic                                clock,
  input  logic                                reset,
  input  parser_out_struct                    in_req,
  output logic                                in_ready,
  output parser_out_struct                    out_req,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(QUEUE_DEPTH):0]        occupancy,
  output logic                                full,
  output logic                                empty,
  output logic                                head_aged,
  output logic [15:0]                         nop_drops
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [6:0] LIFE_MAX = 7'd127;

  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] occupancy_reg;
  logic [15:0]   nop_drops_reg;

  logic [31:0] clk_mem  [QUEUE_DEPTH];
  op_t         op_mem   [QUEUE_DEPTH];
  logic [31:0] addr_mem [QUEUE_DEPTH];
  logic [6:0]  life_vec [QUEUE_DEPTH];

  logic push, nop_drop, pop;
  logic unused_in_life;

  assign unused_in_life = ^in_req.life;

  assign full      = (occupancy_reg == CW'(QUEUE_DEPTH));
  assign empty     = (occupancy_reg == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign occupancy = occupancy_reg;
  assign nop_drops = nop_drops_reg;

  assign push     = in_req.op_ready_s && in_ready && (in_req.opcode != NOP);
  assign nop_drop = in_req.op_ready_s && in_ready && (in_req.opcode == NOP);
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      occupancy_reg <= '0;
      nop_drops_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   occupancy_reg <= occupancy_reg + 1'b1;
        2'b01:   occupancy_reg <= occupancy_reg - 1'b1;
        default: occupancy_reg <= occupancy_reg;
      endcase
      if (nop_drop && (nop_drops_reg != 16'hFFFF))
        nop_drops_reg <= nop_drops_reg + 16'd1;
    end
  end

  // Payload fields never need clearing: validity comes from pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      clk_mem[wr_ptr_reg]  <= in_req.CPU_clock_count;
      op_mem[wr_ptr_reg]   <= in_req.opcode;
      addr_mem[wr_ptr_reg] <= in_req.address;
    end
  end

  // Per-slot life counters; a slot is live when it lies within occupancy of rd_ptr.
  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
    localparam logic [PW-1:0] IDX = PW'(gi);
    logic [PW-1:0] offset;
    logic          slot_valid;
    logic [6:0]    life_reg;

    assign offset     = IDX - rd_ptr_reg;
    assign slot_valid = ({1'b0, offset} < occupancy_reg);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        life_reg <= '0;
      end else if (push && (wr_ptr_reg == IDX)) begin
        life_reg <= '0;
      end else if (slot_valid && !(pop && (rd_ptr_reg == IDX)) && (life_reg != LIFE_MAX)) begin
        life_reg <= life_reg + 7'd1;
      end
    end

    assign life_vec[gi] = life_reg;
  end

  always_comb begin
    out_req        = '0;
    out_req.opcode = NOP;
    if (out_valid) begin
      out_req.CPU_clock_count = clk_mem[rd_ptr_reg];
      out_req.opcode          = op_mem[rd_ptr_reg];
      out_req.address         = addr_mem[rd_ptr_reg];
      out_req.life            = life_vec[rd_ptr_reg];
      out_req.op_ready_s      = 1'b1;
    end
  end

  assign head_aged = out_valid && (life_vec[rd_ptr_reg] >= 7'(AGE_LIMIT));

endmodule

// File: tb/tb_mem_request_queue.sv
// Bench for mem_request_queue: directed scenarios plus a randomized run checked
// against a queue-based model of the request stream.
module tb_mem_request_queue;
  import global_defs::*;

  localparam int D  = 16;
  localparam int AL = 100;

  logic             clock = 1'b0;
  logic             reset;
  parser_out_struct in_req;
  parser_out_struct out_req;
  logic             in_ready, out_valid, out_ready, full, empty, head_aged;
  logic [4:0]       occupancy;
  logic [15:0]      nop_drops;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] cc;
    op_t         op;
    logic [31:0] addr;
    int          life;
  } ment_t;

  ment_t mq[$];
  int    m_nops;
  parser_out_struct nop_req;

  mem_request_queue #(.QUEUE_DEPTH(D), .AGE_LIMIT(AL)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_req    (in_req),
    .in_ready  (in_ready),
    .out_req   (out_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .head_aged (head_aged),
    .nop_drops (nop_drops)
  );

  always #5 clock = ~clock;

  task automatic set_req(input bit v, input op_t op, input logic [31:0] addr, input logic [31:0] cc);
    in_req.op_ready_s      = v;
    in_req.opcode          = op;
    in_req.address         = addr;
    in_req.CPU_clock_count = cc;
    in_req.life            = 7'($urandom);
  endtask

  // Advance one edge; the model applies the queue rules to the pre-edge inputs.
  task automatic cycle();
    bit acc, do_push, do_nop, do_pop;
    ment_t e;
    acc     = in_req.op_ready_s && (mq.size() < D);
    do_push = acc && (in_req.opcode != NOP);
    do_nop  = acc && (in_req.opcode == NOP);
    do_pop  = (mq.size() > 0) && out_ready;
    e.cc    = in_req.CPU_clock_count;
    e.op    = in_req.opcode;
    e.addr  = in_req.address;
    e.life  = 0;
    @(posedge clock);
    #1;
    if (do_pop) begin
      $display("t=%0t pop  addr=%h life=%0d", $time, mq[0].addr, mq[0].life);
      void'(mq.pop_front());
    end
    foreach (mq[i]) if (mq[i].life < 127) mq[i].life++;
    if (do_push) begin
      mq.push_back(e);
      $display("t=%0t push addr=%h op=%0d", $time, e.addr, e.op);
    end
    if (do_nop) begin
      if (m_nops < 65535) m_nops++;
      $display("t=%0t drop nop", $time);
    end
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    set_req(0, NOP, 0, 0);
    out_ready = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    mq.delete();
    m_nops = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_req !== nop_req) begin errors++; $display("FAIL reset_out_req got=%h exp=%h", out_req, nop_req); end
    checks++; if (head_aged !== 1'b0) begin errors++; $display("FAIL reset_head_aged got=%b exp=0", head_aged); end
    checks++; if (nop_drops !== 16'd0) begin errors++; $display("FAIL reset_nop_drops got=%0d exp=0", nop_drops); end
  endtask

  task automatic test_single();
    apply_reset();
    set_req(1, DATA_READ, 32'h0000_1F40, 32'd5);
    cycle();
    set_req(0, NOP, 0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_req.address !== 32'h1F40) begin errors++; $display("FAIL single_addr got=%h exp=1f40", out_req.address); end
    checks++; if (out_req.CPU_clock_count !== 32'd5) begin errors++; $display("FAIL single_cc got=%0d exp=5", out_req.CPU_clock_count); end
    checks++; if (out_req.opcode !== DATA_READ) begin errors++; $display("FAIL single_op got=%0d exp=%0d", out_req.opcode, DATA_READ); end
    checks++; if (out_req.life !== 7'd0) begin errors++; $display("FAIL single_life0 got=%0d exp=0", out_req.life); end
    checks++; if (out_req.op_ready_s !== 1'b1) begin errors++; $display("FAIL single_strobe got=%b exp=1", out_req.op_ready_s); end
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL single_occ got=%0d exp=1", occupancy); end
    repeat (10) cycle();
    checks++; if (out_req.life !== 7'd10) begin errors++; $display("FAIL single_life10 got=%0d exp=10", out_req.life); end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < D; i++) begin
      set_req(1, DATA_WRITE, 32'(i), 32'(i));
      cycle();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    set_req(1, DATA_WRITE, 32'd99, 32'd99);
    cycle();
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL fill_overflow_occ got=%0d exp=16", occupancy); end
    set_req(0, NOP, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      checks++; if (out_req.address !== 32'(i)) begin errors++; $display("FAIL fill_order[%0d] got=%0d exp=%0d", i, out_req.address, i); end
      cycle();
    end
    out_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    int exp_addr[8];
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      set_req(1, DATA_READ, 32'(100 + i), 32'(i));
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1, DATA_WRITE, 32'(200 + i), 32'(i));
      checks++; if (out_req.address !== 32'(100 + i)) begin errors++; $display("FAIL simul_head[%0d] got=%0d exp=%0d", i, out_req.address, 100 + i); end
      cycle();
      checks++; if (occupancy !== 5'd8) begin errors++; $display("FAIL simul_occ8[%0d] got=%0d exp=8", i, occupancy); end
    end
    set_req(0, NOP, 0, 0);
    for (int i = 0; i < 8; i++) exp_addr[i] = (i < 4) ? 104 + i : 196 + i;
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_req.address !== 32'(exp_addr[i])) begin errors++; $display("FAIL simul_drain[%0d] got=%0d exp=%0d", i, out_req.address, exp_addr[i]); end
      cycle();
    end
    apply_reset();
    for (int i = 0; i < D; i++) begin
      set_req(1, DATA_WRITE, 32'(i), 32'(i));
      cycle();
    end
    set_req(1, DATA_WRITE, 32'd77, 32'd77);
    out_ready = 1'b1;
    cycle();
    checks++; if (occupancy !== 5'd15) begin errors++; $display("FAIL simul_full_occ got=%0d exp=15", occupancy); end
    apply_reset();
    set_req(1, DATA_READ, 32'd55, 32'd1);
    out_ready = 1'b1;
    cycle();
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL simul_empty_occ got=%0d exp=1", occupancy); end
    checks++; if (out_req.address !== 32'd55) begin errors++; $display("FAIL simul_empty_addr got=%0d exp=55", out_req.address); end
    out_ready = 1'b0;
    set_req(0, NOP, 0, 0);
  endtask

  task automatic test_nop_drop();
    apply_reset();
    set_req(1, OPCODE_FETCH, 32'hA0, 32'd1); cycle();
    for (int i = 0; i < 3; i++) begin set_req(1, NOP, 32'hDEAD, 32'd2); cycle(); end
    set_req(1, OPCODE_FETCH, 32'hB0, 32'd3); cycle();
    set_req(0, NOP, 0, 0);
    checks++; if (occupancy !== 5'd2) begin errors++; $display("FAIL nop_occ got=%0d exp=2", occupancy); end
    checks++; if (nop_drops !== 16'd3) begin errors++; $display("FAIL nop_count got=%0d exp=3", nop_drops); end
    out_ready = 1'b1;
    checks++; if (out_req.opcode !== OPCODE_FETCH || out_req.address !== 32'hA0) begin errors++; $display("FAIL nop_pop0 got=%0d/%h exp=2/a0", out_req.opcode, out_req.address); end
    cycle();
    checks++; if (out_req.opcode !== OPCODE_FETCH || out_req.address !== 32'hB0) begin errors++; $display("FAIL nop_pop1 got=%0d/%h exp=2/b0", out_req.opcode, out_req.address); end
    cycle();
    out_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL nop_empty got=%b exp=1", empty); end
  endtask

  task automatic test_aging();
    int exp_life;
    apply_reset();
    set_req(1, DATA_READ, 32'h40, 32'd9);
    cycle();
    set_req(0, NOP, 0, 0);
    checks++; if (head_aged !== 1'b0) begin errors++; $display("FAIL aging_start got=%b exp=0", head_aged); end
    for (int k = 1; k <= 135; k++) begin
      cycle();
      exp_life = (k > 127) ? 127 : k;
      checks++; if (out_req.life !== 7'(exp_life)) begin errors++; $display("FAIL aging_life[%0d] got=%0d exp=%0d", k, out_req.life, exp_life); end
      checks++; if (head_aged !== (exp_life >= AL)) begin errors++; $display("FAIL aging_flag[%0d] got=%b exp=%b", k, head_aged, exp_life >= AL); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      set_req(1, DATA_WRITE, 32'(i), 32'(i));
      cycle();
    end
    set_req(0, NOP, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL areset_occ got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_req !== nop_req) begin errors++; $display("FAIL areset_out_req got=%h exp=%h", out_req, nop_req); end
    #1;
    reset = 1'b0;
    mq.delete();
    m_nops = 0;
  endtask

  task automatic test_random();
    parser_out_struct exp_req;
    bit hold;
    int shown;
    apply_reset();
    hold  = 0;
    shown = 0;
    for (int n = 0; n < 600; n++) begin
      if (!hold)
        set_req($urandom_range(0, 99) < 60, op_t'($urandom_range(0, 3)), $urandom, 32'(n));
      out_ready = $urandom_range(0, 99) < ((n % 200) < 100 ? 25 : 85);
      hold = in_req.op_ready_s && (mq.size() >= D);
      cycle();
      exp_req = nop_req;
      if (mq.size() > 0) begin
        exp_req.CPU_clock_count = mq[0].cc;
        exp_req.opcode          = mq[0].op;
        exp_req.address         = mq[0].addr;
        exp_req.life            = 7'(mq[0].life);
        exp_req.op_ready_s      = 1'b1;
      end
      checks++;
      if (out_req !== exp_req || occupancy !== 5'(mq.size()) || out_valid !== (mq.size() > 0) ||
          full !== (mq.size() == D) || empty !== (mq.size() == 0) || in_ready !== (mq.size() < D) ||
          head_aged !== (mq.size() > 0 && mq[0].life >= AL) || nop_drops !== 16'(m_nops)) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random[%0d] got req=%h occ=%0d drops=%0d aged=%b exp req=%h occ=%0d drops=%0d",
                   n, out_req, occupancy, nop_drops, head_aged, exp_req, mq.size(), m_nops);
        end
      end
    end
    set_req(0, NOP, 0, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    nop_req        = '0;
    nop_req.opcode = NOP;
    reset          = 1'b1;
    out_ready      = 1'b0;
    set_req(0, NOP, 0, 0);
    m_nops         = 0;
    #2;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_nop_drop();
    test_aging();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_request_queue.md
# mem_request_queue

Bounded in-order request queue between the trace parser and the DRAM command controller. It accepts parsed operations (`parser_out_struct`, from package `global_defs`), discards NOP entries, and holds up to `QUEUE_DEPTH` requests. It tracks each entry's age in its `life` field and presents the oldest request to the downstream controller through a valid/ready handshake. It is the single point of back-pressure for the parser when the memory controller falls behind.

## Interface
- `QUEUE_DEPTH`, 16: entry count; power of two, 2..64.
- `AGE_LIMIT`, 100: head-entry `life` value at which `head_aged` asserts; range 1..127.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in_req` in `$bits(parser_out_struct)`: request from the parser; `in_req.op_ready_s` is the push strobe.
- `in_ready` out 1: queue can accept a request this cycle.
- `out_req` out `$bits(parser_out_struct)`: head entry; `out_req.op_ready_s` equals `out_valid`.
- `out_valid` out 1: the head entry is valid.
- `out_ready` in 1: the controller takes the head entry this cycle.
- `occupancy` out `$clog2(QUEUE_DEPTH)+1`: number of valid entries.
- `full` out 1: `occupancy == QUEUE_DEPTH`.
- `empty` out 1: `occupancy == 0`.
- `head_aged` out 1: `out_valid` and head `life >= AGE_LIMIT`.
- `nop_drops` out 16: count of NOP requests discarded; saturates at 0xFFFF.

## Operation
- Storage is a circular buffer with read pointer `rd_ptr`, write pointer `wr_ptr` and count `occupancy`. Pointers wrap modulo `QUEUE_DEPTH`.
- **Push** occurs when `in_req.op_ready_s && in_ready && in_req.opcode != NOP`.
  - The entry is written at `wr_ptr` with `CPU_clock_count`, `opcode` and `address` copied from `in_req`.
  - The stored `life` is forced to 0; the incoming `life` is ignored.
- **NOP drop** occurs when `in_req.op_ready_s && in_ready && opcode == NOP`. Nothing is stored and `nop_drops` increments.
- **Pop** occurs when `out_valid && out_ready`. `rd_ptr` advances by one.
- `in_ready = !full`. It is computed from the registered `occupancy`, so a pop does not free a slot within the same cycle.
- **Aging:** at every edge, every valid entry that is not popped at that edge increments its `life` by 1, saturating at 127. An entry pushed at an edge starts at 0.
- `occupancy` changes at each edge by +1 on push only, −1 on pop only, and 0 on both or neither.
- **Outputs:**
  - While `out_valid = 1`, `out_req` shows the entry at `rd_ptr` with its current `life`.
  - While `out_valid = 0`, `out_req` is all-zero except `opcode = NOP`.
- Informative status, derived from `occupancy`:
  - EMPTY: 0.
  - ACTIVE: between 1 and `QUEUE_DEPTH-1`.
  - FULL: `QUEUE_DEPTH`.
- **Status transitions:**
  - EMPTY→ACTIVE on push.
  - ACTIVE→FULL on push without pop at `occupancy = QUEUE_DEPTH-1`.
  - FULL→ACTIVE on pop.
  - ACTIVE→EMPTY on pop without push at `occupancy = 1`.

## Timing
- **Reset values:**
  - `occupancy = 0`, `empty = 1`, `full = 0`, `in_ready = 1`.
  - `out_valid = 0`, `out_req` = NOP/zeros, `head_aged = 0`, `nop_drops = 0`.
  - Pointers = 0.
- Reset asserted mid-operation discards all entries asynchronously. Outputs take their reset values without waiting for a clock edge.
- **Push-to-head latency** is one cycle. A push into an empty queue at edge N gives `out_valid = 1` with `life = 0` after edge N, then `life = 1` after edge N+1.
- **Push and pop in the same cycle:**
  - Non-empty, non-full queue: both take effect and `occupancy` is unchanged.
  - Full queue: only the pop takes effect, since `in_ready = 0`.
  - Empty queue: only the push takes effect, since `out_valid = 0`.
- Dequeue happens at the accepting edge. The next entry, if any, appears on `out_req` in the following cycle with no bubble.
- The parser must hold `in_req` stable while `in_req.op_ready_s && !in_ready`. The queue does not latch rejected requests.
- **Outputs and what they follow:**
  - `head_aged` is combinational from the registered head `life`.
  - `full`, `empty`, `occupancy` and `in_ready` are registered-state decodes.

## Test plan
- **Reset and single request:** reset, then push one DATA_READ to 0x0000_1F40 at clock count 5, with `out_ready = 0`.
  - After one edge: `out_valid = 1`, address 0x1F40, `life = 0`, `occupancy = 1`.
  - After 10 more edges: `life = 10`.
- **Fill to full:** push 16 writes at addresses 0..15 with `out_ready = 0`.
  - `full = 1` and `in_ready = 0`.
  - A 17th push with `op_ready_s = 1` is ignored and `occupancy` stays 16.
  - Popping all 16 returns addresses 0..15 in order and ends with `empty = 1`.
- **Simultaneous push and pop:**
  - At `occupancy = 8`: `occupancy` stays 8 and the order is preserved.
  - At full: `occupancy` goes 16→15.
  - At empty: `occupancy` goes 0→1.
- **NOP drop:** drive 3 NOP strobes between 2 OPCODE_FETCH pushes. Expect `occupancy = 2`, `nop_drops = 3`, and only fetches popped.
- **Aging:**
  - Hold one entry with `out_ready = 0`. `head_aged` rises exactly when `life` reaches 100.
  - `life` saturates at 127 after 127 edges and stays there.
- **Async reset mid-operation:** with 5 entries queued, assert `reset` between clock edges. Expect `out_valid = 0`, `occupancy = 0` and `in_ready = 1` before the next edge.
